// File: rtl/sine_pkg.sv
// Shared types and constants for the time-multiplexed sine voice scheduler.
package sine_pkg;

  localparam int LUT_ADDR_W  = 6;
  localparam int AMP_W       = 8;
  localparam int CFG_PHASE_W = 32;

  typedef struct packed {
    logic                   en;
    logic [CFG_PHASE_W-1:0] incr;
  } voice_cfg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Offset-binary LUT sample to two's complement.
  function automatic logic [AMP_W-1:0] ob_to_twos(input logic [AMP_W-1:0] amp);
    return {~amp[AMP_W-1], amp[AMP_W-2:0]};
  endfunction

endpackage

// File: rtl/sine_lut.sv
// Registered 64-entry sine table, offset-binary output (128 = zero).
// Stored as a quarter wave; positive half is floor(128*sin), negative half mirrors with ceil.
module sine_lut
  import sine_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [LUT_ADDR_W-1:0] addr_in,
  output logic [AMP_W-1:0]      amp_out
);

  function automatic logic [7:0] quarter_floor(input logic [4:0] k);
    case (k)
      5'd0:    return 8'd0;
      5'd1:    return 8'd12;
      5'd2:    return 8'd24;
      5'd3:    return 8'd37;
      5'd4:    return 8'd48;
      5'd5:    return 8'd60;
      5'd6:    return 8'd71;
      5'd7:    return 8'd81;
      5'd8:    return 8'd90;
      5'd9:    return 8'd98;
      5'd10:   return 8'd106;
      5'd11:   return 8'd112;
      5'd12:   return 8'd118;
      5'd13:   return 8'd122;
      5'd14:   return 8'd125;
      5'd15:   return 8'd127;
      default: return 8'd127;
    endcase
  endfunction

  function automatic logic [7:0] quarter_ceil(input logic [4:0] k);
    case (k)
      5'd0:    return 8'd0;
      5'd1:    return 8'd13;
      5'd2:    return 8'd25;
      5'd3:    return 8'd38;
      5'd4:    return 8'd49;
      5'd5:    return 8'd61;
      5'd6:    return 8'd72;
      5'd7:    return 8'd82;
      5'd8:    return 8'd91;
      5'd9:    return 8'd99;
      5'd10:   return 8'd107;
      5'd11:   return 8'd113;
      5'd12:   return 8'd119;
      5'd13:   return 8'd123;
      5'd14:   return 8'd126;
      5'd15:   return 8'd128;
      default: return 8'd128;
    endcase
  endfunction

  logic [4:0]       quad_idx_s;
  logic [AMP_W-1:0] amp_s;

  // Fold the address onto the first quarter wave and apply the half-cycle sign.
  always_comb begin
    quad_idx_s = 5'd0;
    if (addr_in[4:0] <= 5'd16) begin
      quad_idx_s = addr_in[4:0];
    end else begin
      quad_idx_s = 5'd0 - addr_in[4:0];
    end
    if (addr_in[5]) begin
      amp_s = 8'd128 - quarter_ceil(quad_idx_s);
    end else begin
      amp_s = 8'd128 + quarter_floor(quad_idx_s);
    end
  end

  // Output register gives the one-cycle read latency.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      amp_out <= 8'h80;
    end else begin
      amp_out <= amp_s;
    end
  end

endmodule

// File: rtl/sine_voice_scheduler.sv
// Walks all voices once per sample tick through one shared sine LUT and emits the signed mix.
module sine_voice_scheduler
  import sine_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = CFG_PHASE_W
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  sample_tick_in,
  input  logic                                  cfg_we_in,
  input  logic [3:0]                            cfg_voice_in,
  input  logic [PHASE_W-1:0]                    cfg_incr_in,
  input  logic                                  cfg_en_in,
  output logic [AMP_W+$clog2(NUM_VOICES)-1:0]   mix_out,
  output logic                                  mix_valid_out,
  output logic                                  busy_out,
  output logic                                  overrun_out
);

  localparam int MIX_W = AMP_W + $clog2(NUM_VOICES);
  localparam int IDX_W = $clog2(NUM_VOICES);

  sched_state_t           state_r;
  logic [IDX_W-1:0]       idx_r;
  voice_cfg_t             live_cfg_r   [NUM_VOICES];
  voice_cfg_t             shadow_cfg_r [NUM_VOICES];
  voice_cfg_t             cfg_next_s   [NUM_VOICES];
  logic [PHASE_W-1:0]     phase_r      [NUM_VOICES];
  logic [MIX_W-1:0]       acc_r;
  logic                   pend_en_r;
  voice_cfg_t             issue_cfg_s;
  logic [PHASE_W-1:0]     issue_phase_s;
  logic [LUT_ADDR_W-1:0]  lut_addr_s;
  logic [AMP_W-1:0]       lut_amp_s;
  logic [AMP_W-1:0]       amp_twos_s;
  logic [MIX_W-1:0]       amp_ext_s;

  // Live config after this cycle's write; the snapshot reads this so a same-cycle write wins.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      cfg_next_s[v] = live_cfg_r[v];
      if (cfg_we_in && (cfg_voice_in == 4'(v))) begin
        cfg_next_s[v].en   = cfg_en_in;
        cfg_next_s[v].incr = CFG_PHASE_W'(cfg_incr_in);
      end else begin
        cfg_next_s[v] = live_cfg_r[v];
      end
    end
  end

  // Select the voice being issued this cycle and form its LUT address.
  always_comb begin
    issue_cfg_s   = '0;
    issue_phase_s = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      issue_cfg_s   = (idx_r == IDX_W'(v)) ? shadow_cfg_r[v] : issue_cfg_s;
      issue_phase_s = (idx_r == IDX_W'(v)) ? phase_r[v]      : issue_phase_s;
    end
    lut_addr_s = issue_phase_s[PHASE_W-1 -: LUT_ADDR_W];
    amp_twos_s = ob_to_twos(lut_amp_s);
    amp_ext_s  = {{(MIX_W-AMP_W){amp_twos_s[AMP_W-1]}}, amp_twos_s};
  end

  sine_lut u_lut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .addr_in (lut_addr_s),
    .amp_out (lut_amp_s)
  );

  // Live config registers, writable in any cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        live_cfg_r[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        live_cfg_r[v] <= cfg_next_s[v];
      end
    end
  end

  // Sample scheduler: snapshot, issue each voice, drain the LUT pipe, publish the mix.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r       <= IDLE;
      idx_r         <= '0;
      acc_r         <= '0;
      pend_en_r     <= 1'b0;
      mix_out       <= '0;
      mix_valid_out <= 1'b0;
      overrun_out   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        shadow_cfg_r[v] <= '0;
        phase_r[v]      <= '0;
      end
    end else begin
      mix_valid_out <= 1'b0;
      pend_en_r     <= 1'b0;
      if (pend_en_r) begin
        acc_r <= acc_r + amp_ext_s;
      end
      if (sample_tick_in && (state_r != IDLE)) begin
        overrun_out <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (sample_tick_in) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              shadow_cfg_r[v] <= cfg_next_s[v];
            end
            acc_r   <= '0;
            idx_r   <= '0;
            state_r <= RUN;
          end
        end
        RUN: begin
          pend_en_r <= issue_cfg_s.en;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (idx_r == IDX_W'(v)) begin
              phase_r[v] <= issue_cfg_s.en ? (phase_r[v] + PHASE_W'(issue_cfg_s.incr)) : '0;
            end
          end
          if (idx_r == IDX_W'(NUM_VOICES - 1)) begin
            state_r <= DRAIN;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DRAIN: begin
          state_r <= DONE;
        end
        DONE: begin
          mix_out       <= acc_r;
          mix_valid_out <= 1'b1;
          state_r       <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy_out = (state_r != IDLE);

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Self-checking bench: directed vector table, hand sequences and randomized traffic vs. a sample-level model.
module tb_sine_voice_scheduler;

  localparam int NV    = 4;
  localparam int MIXW  = 8 + $clog2(NV);
  localparam int LAT   = NV + 3;
  localparam real PI   = 3.14159265358979;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            sample_tick_in;
  logic            cfg_we_in;
  logic [3:0]      cfg_voice_in;
  logic [31:0]     cfg_incr_in;
  logic            cfg_en_in;
  logic [MIXW-1:0] mix_out;
  logic            mix_valid_out;
  logic            busy_out;
  logic            overrun_out;

  int tests  = 0;
  int errors = 0;

  // Sample-level reference: live config, phases, and a countdown to the next result.
  bit [31:0] m_incr [NV];
  bit        m_en   [NV];
  bit [31:0] m_phase[NV];
  int        m_timer;
  int        m_pending;
  int        m_mix;
  bit        m_overrun;

  sine_voice_scheduler #(.NUM_VOICES(NV), .PHASE_W(32)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .sample_tick_in (sample_tick_in),
    .cfg_we_in      (cfg_we_in),
    .cfg_voice_in   (cfg_voice_in),
    .cfg_incr_in    (cfg_incr_in),
    .cfg_en_in      (cfg_en_in),
    .mix_out        (mix_out),
    .mix_valid_out  (mix_valid_out),
    .busy_out       (busy_out),
    .overrun_out    (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic int model_amp(input int addr);
    real r;
    real rn;
    int  a;
    r  = 128.0 * $sin(2.0 * PI * real'(addr) / 64.0);
    rn = $floor(r + 0.5);
    if ((r - rn < 1.0e-6) && (rn - r < 1.0e-6)) a = int'(rn);
    else a = int'($floor(r));
    if (a > 127) a = 127;
    if (a < -128) a = -128;
    return a;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_incr[v] = 32'd0; m_en[v] = 1'b0; m_phase[v] = 32'd0;
    end
    m_timer = 0; m_pending = 0; m_mix = 0; m_overrun = 1'b0;
  endtask

  task automatic model_edge();
    int prev;
    int sum;
    if (rst_in) begin
      model_reset();
      return;
    end
    prev = m_timer;
    if (m_timer > 0) m_timer--;
    if (m_timer == 1) m_mix = m_pending;
    if (cfg_we_in && (int'(cfg_voice_in) < NV)) begin
      m_incr[cfg_voice_in] = cfg_incr_in;
      m_en[cfg_voice_in]   = cfg_en_in;
    end
    if (sample_tick_in) begin
      if (prev <= 1) begin
        sum = 0;
        for (int v = 0; v < NV; v++) begin
          if (m_en[v]) begin
            sum += model_amp(int'(m_phase[v] >> 26));
            m_phase[v] = m_phase[v] + m_incr[v];
          end else begin
            m_phase[v] = 32'd0;
          end
        end
        m_pending = sum;
        m_timer   = LAT;
      end else begin
        m_overrun = 1'b1;
      end
    end
  endtask

  task automatic check_cycle();
    bit ev;
    bit eb;
    ev = (m_timer == 1);
    eb = (m_timer >= 2);
    tests++;
    if (mix_valid_out !== ev || busy_out !== eb || overrun_out !== m_overrun ||
        int'($signed(mix_out)) != m_mix) begin
      errors++;
      $display("FAIL cycle_check t=%0t: got valid=%0b busy=%0b ovr=%0b mix=%0d, expected valid=%0b busy=%0b ovr=%0b mix=%0d",
               $time, mix_valid_out, busy_out, overrun_out, $signed(mix_out), ev, eb, m_overrun, m_mix);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic we, input logic [3:0] v,
                      input logic [31:0] inc, input logic e);
    sample_tick_in = t; cfg_we_in = we; cfg_voice_in = v; cfg_incr_in = inc; cfg_en_in = e;
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    idle(2);
    rst_in = 1'b0;
    idle(1);
  endtask

  // Called right after the tick cycle; returns cycles from tick to pulse and the mix seen.
  task automatic wait_valid(output int lat, output int mix);
    lat = 1;
    while (!mix_valid_out && lat < 20) begin
      idle(1);
      lat++;
    end
    mix = int'($signed(mix_out));
  endtask

  typedef struct {
    logic [31:0] incr0;
    logic [31:0] incr1;
    logic [1:0]  en;
    int          nticks;
    int          exp_mix[5];
  } vec_t;

  vec_t vecs[3];

  task automatic run_vec(input int i, input string tag);
    int lat;
    int mix;
    do_reset();
    step(1'b0, 1'b1, 4'd0, vecs[i].incr0, vecs[i].en[0]);
    step(1'b0, 1'b1, 4'd1, vecs[i].incr1, vecs[i].en[1]);
    for (int t = 0; t < vecs[i].nticks; t++) begin
      step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
      wait_valid(lat, mix);
      check_int($sformatf("%s_v%0d_lat%0d", tag, i, t), lat, LAT);
      check_int($sformatf("%s_v%0d_mix%0d", tag, i, t), mix, vecs[i].exp_mix[t]);
      idle(1);
    end
  endtask

  initial begin
    int lat;
    int mix;
    int pulses;

    rst_in = 1'b1; sample_tick_in = 1'b0; cfg_we_in = 1'b0;
    cfg_voice_in = 4'd0; cfg_incr_in = 32'd0; cfg_en_in = 1'b0;
    model_reset();

    vecs[0] = '{32'h0400_0000, 32'h0000_0000, 2'b01, 4, '{0, 12, 24, 37, 0}};
    vecs[1] = '{32'h0400_0000, 32'h0400_0000, 2'b11, 3, '{0, 24, 48, 0, 0}};
    vecs[2] = '{32'h4000_0000, 32'h0000_0000, 2'b01, 5, '{0, 127, 0, -128, 0}};

    do_reset();
    check_int("reset_mix", int'(mix_out), 0);
    check_int("reset_flags", int'({mix_valid_out, busy_out, overrun_out}), 0);

    for (int i = 0; i < 3; i++) run_vec(i, "table");

    // Second tick lands two cycles into a sample.
    do_reset();
    step(1'b0, 1'b1, 4'd0, 32'h0400_0000, 1'b1);
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
    pulses = (mix_valid_out === 1'b1) ? 1 : 0;
    for (int i = 0; i < 15; i++) begin
      idle(1);
      if (mix_valid_out === 1'b1) pulses++;
    end
    check_int("overrun_pulses", pulses, 1);
    check_int("overrun_sticky", int'(overrun_out), 1);

    // Retune mid-sample, then writes to out-of-range voice indices.
    do_reset();
    step(1'b0, 1'b1, 4'd0, 32'h0400_0000, 1'b1);
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 4'd0, 32'h4000_0000, 1'b1);
    wait_valid(lat, mix);
    check_int("retune_s1", mix, 0);
    idle(1);
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
    wait_valid(lat, mix);
    check_int("retune_s2", mix, 12);
    idle(1);
    step(1'b0, 1'b1, 4'd9, 32'h0400_0000, 1'b1);
    step(1'b0, 1'b1, 4'd12, 32'h0000_0000, 1'b0);
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
    wait_valid(lat, mix);
    check_int("retune_s3", mix, 127);
    idle(1);
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
    wait_valid(lat, mix);
    check_int("badidx_s4", mix, -13);
    idle(1);

    // Reset in the middle of a sample, then scenario 1 again.
    run_vec(0, "prerst");
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
    idle(1);
    rst_in = 1'b1;
    #1;
    check_int("midrst_mix", int'(mix_out), 0);
    check_int("midrst_flags", int'({mix_valid_out, busy_out, overrun_out}), 0);
    model_reset();
    run_vec(0, "postrst");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] inc;
      case ($urandom_range(0, 3))
        0:       inc = 32'h0400_0000;
        1:       inc = 32'h4000_0000;
        default: inc = $urandom;
      endcase
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)), inc, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
